// File: rtl/stage4_memory_pkg.sv
// stage4_memory_pkg
// Shared types and constants for the memory-access pipeline stage.
//   WORD_W / INSTR_W        : datapath and instruction-class flag widths
//   DO_LOAD / DO_STORE      : bit positions of the load/store flags in instr_type
//   mem_size_t              : funct3 encoding of the access size
//   mem_state_t             : transaction FSM states
//   misaligned_access()     : alignment test used when MISALIGN_TRAP_EN is defined
package stage4_memory_pkg;

  localparam int WORD_W   = 32;
  localparam int INSTR_W  = 8;
  localparam int DO_LOAD  = 0;
  localparam int DO_STORE = 1;

  typedef enum logic [2:0] {
    SZ_B  = 3'd0,
    SZ_H  = 3'd1,
    SZ_W  = 3'd2,
    SZ_BU = 3'd4,
    SZ_HU = 3'd5
  } mem_size_t;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    WAIT
  } mem_state_t;

  // Halfwords must sit on an even address, words on a multiple of four.
  function automatic logic misaligned_access(input mem_size_t size, input logic [1:0] addrLo);
    logic result;
    result = 1'b0;
    case (size)
      SZ_H, SZ_HU: result = addrLo[0];
      SZ_W:        result = (addrLo != 2'b00);
      default:     result = 1'b0;
    endcase
    return result;
  endfunction

endpackage

// File: rtl/stage4_memory_load_extend.sv
// load_extend
// Combinational lane select and sign/zero extension of a load response.
//   rdata    in  word : raw 32-bit word returned by data memory
//   addr_lo  in  2    : low address bits selecting the byte/halfword lane
//   mem_size in       : access size / signedness (mem_size_t)
//   data     out word : write-back-ready load value
module load_extend
  import stage4_memory_pkg::*;
(
  input  logic [WORD_W-1:0] rdata,
  input  logic [1:0]        addr_lo,
  input  mem_size_t         mem_size,
  output logic [WORD_W-1:0] data
);

  logic [7:0]  byteLane;
  logic [15:0] halfLane;

  // Pick the addressed byte and halfword out of the returned word. A halfword
  // only ever looks at addr_lo[1], so an odd halfword address falls back to
  // its naturally aligned lane.
  always_comb begin
    byteLane = rdata[7:0];
    case (addr_lo)
      2'd0:    byteLane = rdata[7:0];
      2'd1:    byteLane = rdata[15:8];
      2'd2:    byteLane = rdata[23:16];
      default: byteLane = rdata[31:24];
    endcase
    halfLane = addr_lo[1] ? rdata[31:16] : rdata[15:0];
  end

  // Widen the selected lane; anything that is not a byte or halfword access
  // passes the whole word through untouched.
  always_comb begin
    data = rdata;
    case (mem_size)
      SZ_B:    data = {{24{byteLane[7]}}, byteLane};
      SZ_BU:   data = {24'd0, byteLane};
      SZ_H:    data = {{16{halfLane[15]}}, halfLane};
      SZ_HU:   data = {16'd0, halfLane};
      default: data = rdata;
    endcase
  end

endmodule

// File: rtl/stage4_memory.sv
// stage4_memory
// Memory-access stage: runs one data-memory transaction per load/store over a
// valid/ready request + rvalid response handshake, stalls upstream while busy,
// and presents a registered write-back result to the next stage.
// Optional feature macro: MISALIGN_TRAP_EN (adds the misalign output and traps
// misaligned halfword/word accesses instead of issuing them).
//   clock, reset                 : rising-edge clock, synchronous active-high reset
//   in_valid, instr_type, mem_size, rd, eval, rs2_val : execute-stage result
//   stall                        : upstream must hold its current instruction
//   dmem_req/we/addr/be/wdata    : memory request, held until dmem_ready
//   dmem_ready                   : request accepted this cycle
//   dmem_rvalid, dmem_rdata      : load response
//   out_valid/rd/val/wb          : one-cycle result pulse to write-back
//   misalign                     : trap pulse (MISALIGN_TRAP_EN only)
module stage4_memory
  import stage4_memory_pkg::*;
(
  input  logic               clock,
  input  logic               reset,
  input  logic               in_valid,
  input  logic [INSTR_W-1:0] instr_type,
  input  logic [2:0]         mem_size,
  input  logic [4:0]         rd,
  input  logic [WORD_W-1:0]  eval,
  input  logic [WORD_W-1:0]  rs2_val,
  output logic               stall,
  output logic               dmem_req,
  output logic               dmem_we,
  output logic [WORD_W-1:0]  dmem_addr,
  output logic [3:0]         dmem_be,
  output logic [WORD_W-1:0]  dmem_wdata,
  input  logic               dmem_ready,
  input  logic               dmem_rvalid,
  input  logic [WORD_W-1:0]  dmem_rdata,
  output logic               out_valid,
  output logic [4:0]         out_rd,
  output logic [WORD_W-1:0]  out_val,
`ifdef MISALIGN_TRAP_EN
  output logic               misalign,
`endif
  output logic               out_wb
);

  mem_state_t        state_q,     state_d;
  logic [4:0]        rd_q,        rd_d;
  logic [WORD_W-1:0] addr_q,      addr_d;
  mem_size_t         size_q,      size_d;
  logic              isLoad_q,    isLoad_d;
  logic              we_q,        we_d;
  logic [3:0]        be_q,        be_d;
  logic [WORD_W-1:0] wdata_q,     wdata_d;
  logic              outValid_q,  outValid_d;
  logic [4:0]        outRd_q,     outRd_d;
  logic [WORD_W-1:0] outVal_q,    outVal_d;
  logic              outWb_q,     outWb_d;
  logic              misalign_q,  misalign_d;

  mem_size_t         inSize;
  logic              inLoad;
  logic              inStore;
  logic [3:0]        laneBe;
  logic [WORD_W-1:0] laneWdata;
  logic [WORD_W-1:0] loadData;

  assign inSize  = mem_size_t'(mem_size);
  assign inLoad  = instr_type[DO_LOAD];
  assign inStore = instr_type[DO_STORE];

  load_extend u_load_extend (
    .rdata    (dmem_rdata),
    .addr_lo  (addr_q[1:0]),
    .mem_size (size_q),
    .data     (loadData)
  );

  // Byte enables and replicated write data are formed from the incoming
  // instruction so they can be captured once and held for the whole request.
  always_comb begin
    laneBe    = 4'b1111;
    laneWdata = rs2_val;
    case (inSize)
      SZ_B, SZ_BU: begin
        laneBe    = 4'b0001 << eval[1:0];
        laneWdata = {4{rs2_val[7:0]}};
      end
      SZ_H, SZ_HU: begin
        laneBe    = eval[1] ? 4'b1100 : 4'b0011;
        laneWdata = {2{rs2_val[15:0]}};
      end
      default: begin
        laneBe    = 4'b1111;
        laneWdata = rs2_val;
      end
    endcase
  end

  // Next-state and result logic. Result registers hold by default, but the
  // valid/wb/misalign flags default low so each result is a single pulse.
  // A word flagged as both load and store is treated as a load.
  always_comb begin
    state_d    = state_q;
    rd_d       = rd_q;
    addr_d     = addr_q;
    size_d     = size_q;
    isLoad_d   = isLoad_q;
    we_d       = we_q;
    be_d       = be_q;
    wdata_d    = wdata_q;
    outValid_d = 1'b0;
    outRd_d    = outRd_q;
    outVal_d   = outVal_q;
    outWb_d    = 1'b0;
    misalign_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          if (inLoad || inStore) begin
`ifdef MISALIGN_TRAP_EN
            if (misaligned_access(inSize, eval[1:0])) begin
              outValid_d = 1'b1;
              outRd_d    = rd;
              outVal_d   = eval;
              misalign_d = 1'b1;
            end else begin
`else
            begin
`endif
              state_d  = REQ;
              rd_d     = rd;
              addr_d   = eval;
              size_d   = inSize;
              isLoad_d = inLoad;
              we_d     = !inLoad;
              be_d     = laneBe;
              wdata_d  = laneWdata;
            end
          end else begin
            outValid_d = 1'b1;
            outRd_d    = rd;
            outVal_d   = eval;
            outWb_d    = (rd != 5'd0);
          end
        end
      end
      REQ: begin
        if (dmem_ready) begin
          if (isLoad_q) begin
            state_d = WAIT;
          end else begin
            state_d    = IDLE;
            outValid_d = 1'b1;
            outRd_d    = rd_q;
          end
        end
      end
      WAIT: begin
        if (dmem_rvalid) begin
          state_d    = IDLE;
          outValid_d = 1'b1;
          outRd_d    = rd_q;
          outVal_d   = loadData;
          outWb_d    = (rd_q != 5'd0);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and capture registers; reset abandons any transaction in flight.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= IDLE;
      rd_q       <= '0;
      addr_q     <= '0;
      size_q     <= SZ_W;
      isLoad_q   <= 1'b0;
      we_q       <= 1'b0;
      be_q       <= '0;
      wdata_q    <= '0;
      outValid_q <= 1'b0;
      outRd_q    <= '0;
      outVal_q   <= '0;
      outWb_q    <= 1'b0;
      misalign_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      rd_q       <= rd_d;
      addr_q     <= addr_d;
      size_q     <= size_d;
      isLoad_q   <= isLoad_d;
      we_q       <= we_d;
      be_q       <= be_d;
      wdata_q    <= wdata_d;
      outValid_q <= outValid_d;
      outRd_q    <= outRd_d;
      outVal_q   <= outVal_d;
      outWb_q    <= outWb_d;
      misalign_q <= misalign_d;
    end
  end

  // Outputs come straight from registered state, so stall has no path from in_valid.
  assign stall      = (state_q != IDLE);
  assign dmem_req   = (state_q == REQ);
  assign dmem_we    = (state_q == REQ) && we_q;
  assign dmem_addr  = {addr_q[WORD_W-1:2], 2'b00};
  assign dmem_be    = be_q;
  assign dmem_wdata = wdata_q;
  assign out_valid  = outValid_q;
  assign out_rd     = outRd_q;
  assign out_val    = outVal_q;
  assign out_wb     = outWb_q;
`ifdef MISALIGN_TRAP_EN
  assign misalign   = misalign_q;
`else
  logic unusedMisalign;
  assign unusedMisalign = misalign_q;
`endif

endmodule

// File: tb/tb_stage4_memory.sv
// tb_stage4_memory
// Self-checking bench for stage4_memory: directed cases plus randomized
// ALU/load/store traffic checked against an arithmetic reference model.
// Honours MISALIGN_TRAP_EN when defined.
module tb_stage4_memory;
  import stage4_memory_pkg::*;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        inValid = 1'b0;
  logic [7:0]  instrType = '0;
  logic [2:0]  memSize = '0;
  logic [4:0]  rdIn = '0;
  logic [31:0] evalIn = '0;
  logic [31:0] rs2Val = '0;
  logic        stall;
  logic        dmemReq;
  logic        dmemWe;
  logic [31:0] dmemAddr;
  logic [3:0]  dmemBe;
  logic [31:0] dmemWdata;
  logic        dmemReady = 1'b0;
  logic        dmemRvalid = 1'b0;
  logic [31:0] dmemRdata = '0;
  logic        outValid;
  logic [4:0]  outRd;
  logic [31:0] outVal;
  logic        outWb;
`ifdef MISALIGN_TRAP_EN
  logic        misalign;
`endif

  int checks = 0;
  int passed = 0;

  localparam logic [7:0] CLS_ALU   = 8'h04;
  localparam logic [7:0] CLS_LOAD  = 8'h01 << DO_LOAD;
  localparam logic [7:0] CLS_STORE = 8'h01 << DO_STORE;

  stage4_memory dut (
    .clock       (clock),
    .reset       (reset),
    .in_valid    (inValid),
    .instr_type  (instrType),
    .mem_size    (memSize),
    .rd          (rdIn),
    .eval        (evalIn),
    .rs2_val     (rs2Val),
    .stall       (stall),
    .dmem_req    (dmemReq),
    .dmem_we     (dmemWe),
    .dmem_addr   (dmemAddr),
    .dmem_be     (dmemBe),
    .dmem_wdata  (dmemWdata),
    .dmem_ready  (dmemReady),
    .dmem_rvalid (dmemRvalid),
    .dmem_rdata  (dmemRdata),
    .out_valid   (outValid),
    .out_rd      (outRd),
    .out_val     (outVal),
`ifdef MISALIGN_TRAP_EN
    .misalign    (misalign),
`endif
    .out_wb      (outWb)
  );

  always #5 clock = ~clock;

  // Move to 1 time unit after the next rising edge: outputs settled, inputs safe to change.
  task automatic step();
    @(posedge clock);
    #1;
  endtask

  // Reference model: lane value as plain shift/mask arithmetic, then sign fix-up by subtraction.
  function automatic logic [31:0] expLoad(input logic [2:0] sz, input logic [31:0] a, input logic [31:0] data);
    int sh;
    int w;
    logic [31:0] v;
    if (sz == 3'd0 || sz == 3'd4) begin
      sh = 8 * int'(a % 4);
      w = 8;
    end else if (sz == 3'd1 || sz == 3'd5) begin
      sh = 16 * int'((a / 2) % 2);
      w = 16;
    end else begin
      return data;
    end
    v = (data >> sh) & ((32'd1 << w) - 32'd1);
    if (sz < 3'd4 && v >= (32'd1 << (w - 1))) v = v - (32'd1 << w);
    return v;
  endfunction

  function automatic logic [3:0] expBe(input logic [2:0] sz, input logic [31:0] a);
    if (sz == 3'd0) return 4'(1 << (a % 4));
    if (sz == 3'd1) return 4'(3 << (2 * ((a / 2) % 2)));
    return 4'hF;
  endfunction

  function automatic logic [31:0] expWdata(input logic [2:0] sz, input logic [31:0] v);
    if (sz == 3'd0) return (v & 32'hFF) * 32'h01010101;
    if (sz == 3'd1) return (v & 32'hFFFF) * 32'h00010001;
    return v;
  endfunction

  task automatic test_reset();
    reset = 1'b1;
    step();
    step();
    checks++; if (stall !== 1'b0) $display("[TB] FAIL reset_stall got=%b want=0", stall); else passed++;
    checks++; if (dmemReq !== 1'b0 || dmemWe !== 1'b0) $display("[TB] FAIL reset_req got=%b%b want=00", dmemReq, dmemWe); else passed++;
    checks++; if (outValid !== 1'b0 || outWb !== 1'b0) $display("[TB] FAIL reset_out got=%b%b want=00", outValid, outWb); else passed++;
    checks++; if (dmemAddr !== 32'd0 || dmemBe !== 4'd0 || dmemWdata !== 32'd0)
      $display("[TB] FAIL reset_bus got addr=%h be=%b wdata=%h want zeros", dmemAddr, dmemBe, dmemWdata); else passed++;
    checks++; if (outVal !== 32'd0 || outRd !== 5'd0) $display("[TB] FAIL reset_result got val=%h rd=%0d want 0", outVal, outRd); else passed++;
`ifdef MISALIGN_TRAP_EN
    checks++; if (misalign !== 1'b0) $display("[TB] FAIL reset_misalign got=%b want=0", misalign); else passed++;
`endif
    reset = 1'b0;
    step();
  endtask

  task automatic test_alu(input logic [31:0] ev, input logic [4:0] rdv);
    inValid = 1'b1; instrType = CLS_ALU; memSize = 3'($urandom_range(0, 2)); rdIn = rdv; evalIn = ev; rs2Val = $urandom;
    checks++; if (stall !== 1'b0) $display("[TB] FAIL alu_stall got=%b want=0", stall); else passed++;
    step();
    inValid = 1'b0;
    checks++; if (outValid !== 1'b1 || outVal !== ev || outRd !== rdv || outWb !== (rdv != 5'd0) || stall !== 1'b0)
      $display("[TB] FAIL alu_result got v=%b val=%h rd=%0d wb=%b stall=%b want v=1 val=%h rd=%0d wb=%b stall=0",
               outValid, outVal, outRd, outWb, stall, ev, rdv, rdv != 5'd0); else passed++;
    step();
    checks++; if (outValid !== 1'b0) $display("[TB] FAIL alu_pulse got=%b want=0", outValid); else passed++;
  endtask

  task automatic test_store(input logic [2:0] sz, input logic [31:0] ev, input logic [31:0] data, input int rdyDelay);
    logic [4:0] rdv;
    rdv = 5'($urandom);
    inValid = 1'b1; instrType = CLS_STORE; memSize = sz; rdIn = rdv; evalIn = ev; rs2Val = data;
    step();
    inValid = 1'b0; instrType = CLS_ALU; rs2Val = $urandom; evalIn = $urandom;
    for (int i = 0; i <= rdyDelay; i++) begin
      dmemReady = (i == rdyDelay);
      checks++; if (dmemReq !== 1'b1 || dmemWe !== 1'b1 || stall !== 1'b1 || outValid !== 1'b0 ||
                    dmemAddr !== (ev & ~32'd3) || dmemBe !== expBe(sz, ev) || dmemWdata !== expWdata(sz, data))
        $display("[TB] FAIL store_req got req=%b we=%b stall=%b v=%b addr=%h be=%b wd=%h want 1 1 1 0 addr=%h be=%b wd=%h",
                 dmemReq, dmemWe, stall, outValid, dmemAddr, dmemBe, dmemWdata, ev & ~32'd3, expBe(sz, ev), expWdata(sz, data));
      else passed++;
      step();
    end
    dmemReady = 1'b0;
    checks++; if (outValid !== 1'b1 || outWb !== 1'b0 || outRd !== rdv || stall !== 1'b0 || dmemReq !== 1'b0)
      $display("[TB] FAIL store_done got v=%b wb=%b rd=%0d stall=%b req=%b want 1 0 %0d 0 0", outValid, outWb, outRd, stall, dmemReq, rdv);
    else passed++;
    step();
    checks++; if (outValid !== 1'b0) $display("[TB] FAIL store_pulse got=%b want=0", outValid); else passed++;
  endtask

  task automatic test_load(input logic [2:0] sz, input logic [31:0] ev, input logic [31:0] data, input logic [4:0] rdv,
                           input int rdyDelay, input int rvDelay, input bit rvalidWithReady);
    logic [31:0] want;
    want = expLoad(sz, ev, data);
    inValid = 1'b1; instrType = CLS_LOAD; memSize = sz; rdIn = rdv; evalIn = ev; rs2Val = $urandom;
    step();
    inValid = 1'b0; instrType = CLS_ALU; evalIn = $urandom;
    for (int i = 0; i <= rdyDelay; i++) begin
      dmemReady = (i == rdyDelay);
      dmemRvalid = rvalidWithReady && (i == rdyDelay);
      dmemRdata = $urandom;
      checks++; if (dmemReq !== 1'b1 || dmemWe !== 1'b0 || stall !== 1'b1 || outValid !== 1'b0 || dmemAddr !== (ev & ~32'd3))
        $display("[TB] FAIL load_req got req=%b we=%b stall=%b v=%b addr=%h want 1 0 1 0 addr=%h",
                 dmemReq, dmemWe, stall, outValid, dmemAddr, ev & ~32'd3);
      else passed++;
      step();
    end
    dmemReady = 1'b0; dmemRvalid = 1'b0;
    for (int j = 0; j < rvDelay; j++) begin
      checks++; if (dmemReq !== 1'b0 || stall !== 1'b1 || outValid !== 1'b0)
        $display("[TB] FAIL load_wait got req=%b stall=%b v=%b want 0 1 0", dmemReq, stall, outValid);
      else passed++;
      step();
    end
    dmemRvalid = 1'b1; dmemRdata = data;
    step();
    dmemRvalid = 1'b0; dmemRdata = $urandom;
    checks++; if (outValid !== 1'b1 || outVal !== want || outRd !== rdv || outWb !== (rdv != 5'd0) || stall !== 1'b0)
      $display("[TB] FAIL load_result got v=%b val=%h rd=%0d wb=%b stall=%b want v=1 val=%h rd=%0d wb=%b stall=0",
               outValid, outVal, outRd, outWb, stall, want, rdv, rdv != 5'd0);
    else passed++;
    step();
    checks++; if (outValid !== 1'b0) $display("[TB] FAIL load_pulse got=%b want=0", outValid); else passed++;
  endtask

  task automatic test_stray_rvalid();
    dmemRvalid = 1'b1; dmemRdata = 32'hDEADBEEF;
    step();
    step();
    dmemRvalid = 1'b0;
    checks++; if (outValid !== 1'b0 || stall !== 1'b0) $display("[TB] FAIL idle_rvalid got v=%b stall=%b want 0 0", outValid, stall); else passed++;
  endtask

  task automatic test_reset_mid();
    // Reset while a load sits in WAIT, then a late response.
    inValid = 1'b1; instrType = CLS_LOAD; memSize = 3'd2; rdIn = 5'd9; evalIn = 32'h300;
    step();
    inValid = 1'b0; dmemReady = 1'b1;
    step();
    dmemReady = 1'b0; reset = 1'b1;
    step();
    reset = 1'b0;
    checks++; if (stall !== 1'b0 || dmemReq !== 1'b0 || outValid !== 1'b0 || outWb !== 1'b0 || dmemAddr !== 32'd0 ||
                  dmemBe !== 4'd0 || dmemWdata !== 32'd0 || outVal !== 32'd0 || outRd !== 5'd0)
      $display("[TB] FAIL rst_wait got stall=%b req=%b v=%b wb=%b addr=%h be=%b wd=%h val=%h rd=%0d want all zero",
               stall, dmemReq, outValid, outWb, dmemAddr, dmemBe, dmemWdata, outVal, outRd);
    else passed++;
    dmemRvalid = 1'b1; dmemRdata = 32'h11223344;
    step();
    dmemRvalid = 1'b0;
    checks++; if (outValid !== 1'b0 || stall !== 1'b0) $display("[TB] FAIL rst_late_rvalid got v=%b stall=%b want 0 0", outValid, stall); else passed++;
    step();
    checks++; if (outValid !== 1'b0) $display("[TB] FAIL rst_late_pulse got=%b want=0", outValid); else passed++;
    // Reset while a store is requesting.
    inValid = 1'b1; instrType = CLS_STORE; memSize = 3'd2; rdIn = 5'd3; evalIn = 32'h40; rs2Val = 32'h5A5A5A5A;
    step();
    inValid = 1'b0;
    checks++; if (dmemReq !== 1'b1) $display("[TB] FAIL rst_req_pre got=%b want=1", dmemReq); else passed++;
    reset = 1'b1;
    step();
    reset = 1'b0; dmemReady = 1'b1;
    checks++; if (dmemReq !== 1'b0 || stall !== 1'b0) $display("[TB] FAIL rst_req got req=%b stall=%b want 0 0", dmemReq, stall); else passed++;
    step();
    dmemReady = 1'b0;
    checks++; if (outValid !== 1'b0) $display("[TB] FAIL rst_req_pulse got=%b want=0", outValid); else passed++;
  endtask

  task automatic test_misalign();
`ifdef MISALIGN_TRAP_EN
    inValid = 1'b1; instrType = CLS_LOAD; memSize = 3'd2; rdIn = 5'd7; evalIn = 32'h101;
    checks++; if (stall !== 1'b0) $display("[TB] FAIL trap_stall got=%b want=0", stall); else passed++;
    step();
    inValid = 1'b0;
    checks++; if (dmemReq !== 1'b0 || outValid !== 1'b1 || misalign !== 1'b1 || outWb !== 1'b0 || stall !== 1'b0)
      $display("[TB] FAIL trap got req=%b v=%b mis=%b wb=%b stall=%b want 0 1 1 0 0", dmemReq, outValid, misalign, outWb, stall);
    else passed++;
    step();
    checks++; if (misalign !== 1'b0 || outValid !== 1'b0 || dmemReq !== 1'b0)
      $display("[TB] FAIL trap_pulse got mis=%b v=%b req=%b want 0 0 0", misalign, outValid, dmemReq); else passed++;
`else
    test_load(3'd2, 32'h101, 32'hCAFEF00D, 5'd7, 0, 0, 1'b0);
    test_load(3'd1, 32'h203, 32'h8001BEEF, 5'd8, 1, 1, 1'b0);
    test_store(3'd1, 32'h103, 32'h0000C0DE, 0);
`endif
  endtask

  task automatic test_random_mem(input int n);
    logic [2:0] sz;
    logic [31:0] a;
    for (int k = 0; k < n; k++) begin
      a = $urandom & 32'h0000FFFF;
      if ($urandom_range(0, 1) == 1) begin
        case ($urandom_range(0, 4))
          0: sz = 3'd0;
          1: sz = 3'd1;
          2: sz = 3'd2;
          3: sz = 3'd4;
          default: sz = 3'd5;
        endcase
`ifdef MISALIGN_TRAP_EN
        if (sz == 3'd1 || sz == 3'd5) a[0] = 1'b0;
        if (sz == 3'd2) a[1:0] = 2'b00;
`endif
        test_load(sz, a, $urandom, 5'($urandom), $urandom_range(0, 3), $urandom_range(0, 3), 1'($urandom_range(0, 1)));
      end else begin
        sz = 3'($urandom_range(0, 2));
`ifdef MISALIGN_TRAP_EN
        if (sz == 3'd1) a[0] = 1'b0;
        if (sz == 3'd2) a[1:0] = 2'b00;
`endif
        test_store(sz, a, $urandom, $urandom_range(0, 3));
      end
    end
  endtask

  initial begin
    test_reset();
    test_alu(32'h12345678, 5'd5);
    test_alu($urandom, 5'd0);
    for (int k = 0; k < 8; k++) test_alu($urandom, 5'($urandom));
    test_store(3'd0, 32'h103, 32'h000000AB, 2);
    test_load(3'd0, 32'h202, 32'h00800000, 5'd4, 0, 0, 1'b0);
    test_load(3'd4, 32'h202, 32'h00800000, 5'd4, 1, 0, 1'b0);
    test_load(3'd5, 32'h202, 32'hBEEF0000, 5'd6, 0, 1, 1'b0);
    test_load(3'd2, 32'h400, 32'h89ABCDEF, 5'd10, 1, 4, 1'b0);
    test_load(3'd1, 32'h002, 32'h80000000, 5'd0, 0, 0, 1'b1);
    test_stray_rvalid();
    test_reset_mid();
    test_misalign();
    test_random_mem(24);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/stage4_memory.md
# stage4_memory

Memory-access stage of the 7-stage pipeline, directly downstream of the execute stage. Takes the execute result (`eval` as effective address or ALU value) plus store data and the instruction class, and runs one data-memory transaction per load/store over a valid/ready request and rvalid response handshake. Stalls upstream while a transaction is in flight. Presents a registered, write-back-ready result (sign/zero-extended load data or passed-through `eval`) to the next stage.

## Interface
Parameters: none (widths from `word` and `definitions.vh`).
- `clock` in 1: sole clock, rising edge
- `reset` in 1: synchronous, active-high
- `in_valid` in 1: execute result valid this cycle
- `instr_type` in `range_instrs`: class flags; uses `do_load`, `do_store`
- `mem_size` in 3: funct3: 0 LB/SB, 1 LH/SH, 2 LW/SW, 4 LBU, 5 LHU
- `rd` in 5: destination register
- `eval` in word: effective address (mem ops) or ALU result
- `rs2_val` in word: store data
- `stall` out 1: upstream must hold and not present new work
- `dmem_req` out 1; `dmem_we` out 1; `dmem_addr` out word (bits [1:0] = 0); `dmem_be` out 4; `dmem_wdata` out word
- `dmem_ready` in 1: request accepted this cycle
- `dmem_rvalid` in 1; `dmem_rdata` in word: load response
- `out_valid` out 1; `out_rd` out 5; `out_val` out word; `out_wb` out 1: result to next stage
- `misalign` out 1: only with `MISALIGN_TRAP_EN`

## Operation
- Acceptance: input taken when `in_valid && !stall`; `rd`, `eval`, `rs2_val`, `mem_size`, class latched into capture registers.
- FSM states IDLE, REQ, WAIT. `stall` = (state != IDLE).
- IDLE, non-memory op accepted: next cycle `out_valid`=1, `out_val`=`eval`, `out_wb`=(`rd`!=0); stay IDLE.
- IDLE, load/store accepted: -> REQ.
- REQ: `dmem_req`=1, address/be/wdata/we stable until `dmem_ready`. On ready: store -> IDLE, with `out_valid`=1, `out_wb`=0 next cycle; load -> WAIT.
- WAIT: on `dmem_rvalid`: -> IDLE; next cycle `out_valid`=1, `out_val`=extended data, `out_wb`=(`rd`!=0).
- `dmem_rvalid` outside WAIT ignored.
- Store lanes: SB `dmem_be`=1<<addr[1:0], byte replicated ×4; SH `dmem_be`=0011<<(2·addr[1]), halfword replicated ×2; SW 1111.
- Load extract: byte lane addr[1:0], halfword lane addr[1]; LB/LH sign-extend, LBU/LHU zero-extend, LW unchanged.
- `dmem_addr` = {eval[31:2], 2'b00}.
- `out_valid` is a single-cycle pulse per accepted instruction.

## Timing
- Reset: state IDLE; `stall`, `dmem_req`, `dmem_we`, `out_valid`, `out_wb`, `misalign` = 0; `dmem_addr`, `dmem_be`, `dmem_wdata`, `out_val`, `out_rd` = 0.
- Latency (accept -> `out_valid`): non-memory 1 cycle; store 2 + ready wait; load 3 + ready wait + rvalid wait.
- Reset mid-transaction: abandon at once, `dmem_req` low next cycle, no `out_valid`; late `dmem_rvalid` ignored.
- Ready and rvalid in the same REQ cycle: rvalid ignored; memory gives rvalid no earlier than the cycle after ready.
- `stall` is registered-state only; no combinational path from `in_valid`.

## Configuration
- `MISALIGN_TRAP_EN` defined: halfword with addr[0]=1 or word with addr[1:0]!=0 issues no request; next cycle `out_valid`=1, `misalign`=1, `out_wb`=0; state stays IDLE.
- Undefined: `misalign` port absent; misaligned access uses natural alignment (halfword lane addr[1], word lane 0), no trap.

## Structure
- Shared package: `mem_size_t` enum (SZ_B, SZ_H, SZ_W, SZ_BU, SZ_HU), `mem_state_t` enum (IDLE, REQ, WAIT).
- Sub-module `load_extend`: combinational lane select + sign/zero extension (`rdata`, addr[1:0], `mem_size` -> word).

## Test plan
- ADD result: `eval`=0x12345678, rd=5 -> 1 cycle later `out_val`=0x12345678, `out_wb`=1, `stall` never high.
- SB `eval`=0x103, `rs2_val`=0xAB, ready after 2 cycles -> `dmem_addr`=0x100, `dmem_be`=1000, `dmem_wdata`=0xABABABAB held until ready; `out_wb`=0.
- LB `eval`=0x202, rdata=0x00800000 -> `out_val`=0xFFFFFF80; LBU same -> 0x00000080; LHU `eval`=0x202, rdata=0xBEEF0000 -> 0x0000BEEF.
- LW, rvalid 4 cycles after ready -> `stall` high throughout, no `out_valid` early, one pulse with rdata.
- `reset` while in WAIT, rvalid next cycle -> IDLE, no `out_valid`, all outputs at reset values.
- With `MISALIGN_TRAP_EN`: LW `eval`=0x101 -> no `dmem_req`, `misalign`=1 pulse; without: `dmem_addr`=0x100, normal load.
